// File: rtl/io_pkg.sv
// Shared constants for the board I/O front-ends: default switch width, debounce
// timing and the MMIO address of the committed-switch register.
package io_pkg;

    localparam int unsigned SW_W_DEF     = 16;
    localparam int unsigned DB_DEPTH_DEF = 4;
    localparam int unsigned TICK_DIV_DEF = 100_000;

    localparam logic [31:0] SWITCH_MMIO_ADDR = 32'hFFFF_FC70;

endpackage

// File: rtl/debounce_bit.sv
// One-bit tick-sampled debouncer. With SWITCH_DEBOUNCE_EN undefined it reduces to a
// wire from the synchronised input to the output.
module debounce_bit
    import io_pkg::*;
#(
    parameter int unsigned DB_DEPTH = DB_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din_sync,
    output logic dout
);

`ifdef SWITCH_DEBOUNCE_EN
    logic [DB_DEPTH-1:0] hist_q;
    logic [DB_DEPTH-1:0] hist_d;
    logic                dout_q;
    logic                dout_d;

    always_comb begin
        hist_d = hist_q;
        if (tick) begin
            hist_d = {hist_q[DB_DEPTH-2:0], din_sync};
        end
        // Only a unanimous history moves the output; mixed histories hold it.
        dout_d = dout_q;
        if (&hist_q) begin
            dout_d = 1'b1;
        end else if (~|hist_q) begin
            dout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            dout_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
`else
    logic unused_sink;

    assign dout        = din_sync;
    assign unused_sink = (^{clk, rst, tick}) ^ (DB_DEPTH > 1);
`endif

endmodule

// File: rtl/switch_input_ctrl.sv
// Synchronises and debounces the slide switches and confirm button, then snapshots the
// switches on each confirm press. Debouncing is built only when SWITCH_DEBOUNCE_EN is defined.
module switch_input_ctrl
    import io_pkg::*;
#(
    parameter int unsigned SW_W     = SW_W_DEF,
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int unsigned DB_DEPTH = DB_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw_raw,
    input  logic            btn_raw,
    input  logic            rd_ack,
    output logic [SW_W-1:0] io_rdata_switch,
    output logic [SW_W-1:0] sw_live,
    output logic            sw_valid,
    output logic            confirm_pulse
);

    localparam int unsigned N_IN = SW_W + 1;

    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] sync1_q;
    logic [N_IN-1:0] sync2_q;
    logic [N_IN-1:0] db;
    logic            tick;

    // Button rides in the MSB so it shares the synchroniser and debounce array.
    assign raw_in = {btn_raw, sw_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef SWITCH_DEBOUNCE_EN
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_div;

    assign tick       = 1'b0;
    assign unused_div = (TICK_DIV > 1);
`endif

    for (genvar i = 0; i < N_IN; i++) begin : g_db
        debounce_bit #(
            .DB_DEPTH (DB_DEPTH)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .din_sync (sync2_q[i]),
            .dout     (db[i])
        );
    end

    logic            btn_db;
    logic            btn_db_d;
    logic            btn_edge;
    logic [SW_W-1:0] snap_q;
    logic [SW_W-1:0] snap_d;
    logic            valid_q;
    logic            valid_d;
    logic            pulse_q;
    logic            pulse_d;

    assign sw_live = db[SW_W-1:0];
    assign btn_db  = db[SW_W];

    always_comb begin
        btn_edge = btn_db & ~btn_db_d;
        snap_d   = btn_edge ? sw_live : snap_q;
        pulse_d  = btn_edge;
        // A set outranks an ack, both in the edge cycle and in the strobe cycle that
        // follows, so an ack racing a fresh snapshot cannot drop it.
        valid_d  = btn_edge | pulse_q | (valid_q & ~rd_ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db_d <= 1'b0;
            snap_q   <= '0;
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            btn_db_d <= btn_db;
            snap_q   <= snap_d;
            valid_q  <= valid_d;
            pulse_q  <= pulse_d;
        end
    end

    assign io_rdata_switch = snap_q;
    assign sw_valid        = valid_q;
    assign confirm_pulse   = pulse_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed bench for switch_input_ctrl with TICK_DIV=4, DB_DEPTH=4; expectations adapt to
// whether SWITCH_DEBOUNCE_EN is defined.
module tb_switch_input_ctrl;

    localparam int unsigned SW_W = 16;

`ifdef SWITCH_DEBOUNCE_EN
    localparam bit DB_ON         = 1'b1;
    localparam int LIVE_BOUND    = 23;
    localparam int GLITCH_PULSES = 0;
`else
    localparam bit DB_ON         = 1'b0;
    localparam int LIVE_BOUND    = 2;
    localparam int GLITCH_PULSES = 3;
`endif

    logic            clk;
    logic            rst;
    logic [SW_W-1:0] sw_raw;
    logic            btn_raw;
    logic            rd_ack;
    logic [SW_W-1:0] io_rdata_switch;
    logic [SW_W-1:0] sw_live;
    logic            sw_valid;
    logic            confirm_pulse;

    switch_input_ctrl #(
        .SW_W     (SW_W),
        .TICK_DIV (4),
        .DB_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sw_raw          (sw_raw),
        .btn_raw         (btn_raw),
        .rd_ack          (rd_ack),
        .io_rdata_switch (io_rdata_switch),
        .sw_live         (sw_live),
        .sw_valid        (sw_valid),
        .confirm_pulse   (confirm_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sw;
        logic [15:0] exp_live;
        int          exp_pulses;
        logic [15:0] exp_snap;
        logic        exp_valid_pre;
        logic        do_ack;
        logic        exp_valid_post;
    } vec_t;

    vec_t vecs [5];
    int   total;
    int   bad;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds the button high then low, counting strobes and recording state in the strobe cycle.
    task automatic press(input int hi, input int lo, output int pulses,
                         output logic [15:0] snap_at, output logic valid_at);
        pulses   = 0;
        snap_at  = 16'hDEAD;
        valid_at = 1'b0;
        btn_raw  = 1'b1;
        for (int i = 0; i < hi + lo; i++) begin
            if (i == hi) btn_raw = 1'b0;
            @(negedge clk);
            if (confirm_pulse === 1'b1) begin
                pulses++;
                snap_at  = io_rdata_switch;
                valid_at = sw_valid;
            end
        end
    endtask

    task automatic ack_once();
        rd_ack = 1'b1;
        cyc(1);
        rd_ack = 1'b0;
        cyc(1);
    endtask

    task automatic wait_live(input logic [15:0] target, output int n);
        n = 0;
        while (sw_live !== target && n < 100) begin
            cyc(1);
            n++;
        end
    endtask

    initial begin
        int          n;
        int          pulses;
        logic [15:0] snap_at;
        logic        valid_at;
        logic        seen;
        logic        live0_or;

        total = 0;
        bad   = 0;
        vecs[0] = '{16'hA5C3, 16'hA5C3, 1, 16'hA5C3, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{16'h1234, 16'h1234, 1, 16'h1234, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h00FF, 16'h00FF, 1, 16'h00FF, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 1, 16'h0000, 1'b1, 1'b1, 1'b0};

        rst     = 1'b1;
        sw_raw  = 16'hFFFF;
        btn_raw = 1'b0;
        rd_ack  = 1'b0;
        cyc(3);
        check("reset_rdata", io_rdata_switch, 16'h0000);
        check("reset_live", sw_live, 16'h0000);
        check("reset_valid", 16'(sw_valid), 16'h0000);
        check("reset_pulse", 16'(confirm_pulse), 16'h0000);

        rst = 1'b0;
        wait_live(16'hFFFF, n);
        check("first_live_in_bound", 16'(n <= LIVE_BOUND), 16'h0001);
        press(30, 30, pulses, snap_at, valid_at);
        check("pre_rst_snap", io_rdata_switch, 16'hFFFF);
        check("pre_rst_valid", 16'(sw_valid), 16'h0001);

        // Asynchronous reset asserted between clock edges, mid tick count.
        cyc(2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rdata", io_rdata_switch, 16'h0000);
        check("async_rst_live", sw_live, 16'h0000);
        check("async_rst_valid", 16'(sw_valid), 16'h0000);
        check("async_rst_pulse", 16'(confirm_pulse), 16'h0000);
        cyc(1);
        rst = 1'b0;
        wait_live(16'hFFFF, n);
        check("rst_release_live_in_bound", 16'(n <= LIVE_BOUND), 16'h0001);
        check("rst_release_rdata", io_rdata_switch, 16'h0000);

        for (int v = 0; v < 5; v++) begin
            sw_raw = vecs[v].sw;
            cyc(30);
            check($sformatf("vec%0d_live", v), sw_live, vecs[v].exp_live);
            press(30, 30, pulses, snap_at, valid_at);
            check($sformatf("vec%0d_pulses", v), 16'(pulses), 16'(vecs[v].exp_pulses));
            check($sformatf("vec%0d_snap_in_pulse", v), snap_at, vecs[v].exp_snap);
            check($sformatf("vec%0d_valid_in_pulse", v), 16'(valid_at),
                  16'(vecs[v].exp_valid_pre));
            if (vecs[v].do_ack) ack_once();
            check($sformatf("vec%0d_rdata_after", v), io_rdata_switch, vecs[v].exp_snap);
            check($sformatf("vec%0d_valid_after", v), 16'(sw_valid), 16'(vecs[v].exp_valid_post));
        end

        // Short highs on bit 0: never four consecutive equal tick samples.
        live0_or = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                sw_raw = (i < 5) ? 16'h0001 : 16'h0000;
                cyc(1);
                live0_or = live0_or | sw_live[0];
            end
        end
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            live0_or = live0_or | sw_live[0];
        end
        check("bounce_sw_bit0", 16'(live0_or), 16'(!DB_ON));

        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            btn_raw = (i < 30 && (i % 10) < 5) ? 1'b1 : 1'b0;
            cyc(1);
            if (confirm_pulse === 1'b1) pulses++;
        end
        check("bounce_btn_pulses", 16'(pulses), 16'(GLITCH_PULSES));

        ack_once();
        check("pre_collision_valid", 16'(sw_valid), 16'h0000);
        sw_raw = 16'h5A5A;
        cyc(30);
        btn_raw = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cyc(1);
            if (confirm_pulse === 1'b1) seen = 1'b1;
        end
        check("collision_pulse_seen", 16'(seen), 16'h0001);
        rd_ack = 1'b1;
        cyc(1);
        rd_ack = 1'b0;
        check("collision_valid_kept", 16'(sw_valid), 16'h0001);
        check("collision_snap", io_rdata_switch, 16'h5A5A);
        btn_raw = 1'b0;
        cyc(30);
        ack_once();
        check("lone_ack_valid", 16'(sw_valid), 16'h0000);
        check("lone_ack_snap_held", io_rdata_switch, 16'h5A5A);

        sw_raw = 16'h8001;
        cyc(1);
        check("lat_plus1_old", sw_live, 16'h5A5A);
        cyc(1);
        check("lat_plus2", sw_live, DB_ON ? 16'h5A5A : 16'h8001);
        cyc(30);
        check("lat_settled", sw_live, 16'h8001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/switch_input_ctrl.md
# switch_input_ctrl

Front-end for the board's 16 slide switches and the confirm push-button. Feeds the `io_rdata_switch` input of the data-memory/MMIO stage. Each input is synchronised to `clk` and debounced. On a debounced rising edge of the confirm button, the switch value is snapshotted into a stable register. The CPU therefore reads a value the user has committed, not one that is mid-toggle.

## Interface
Parameters:
- `SW_W`, 16, number of switch inputs.
- `TICK_DIV`, 100_000, `clk` cycles per debounce sample tick (1 ms at 100 MHz); legal range ≥ 2.
- `DB_DEPTH`, 4, number of consecutive equal tick samples required to change a debounced bit.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sw_raw` in `SW_W`: raw switch pins, asynchronous to `clk`.
- `btn_raw` in 1: raw confirm button, asynchronous, active-high.
- `rd_ack` in 1: one-cycle pulse from the MMIO stage after it consumes the snapshot.
- `io_rdata_switch` out `SW_W`: latched snapshot, connects to the MMIO stage.
- `sw_live` out `SW_W`: current debounced switch value.
- `sw_valid` out 1: sticky flag meaning an unconsumed snapshot is present.
- `confirm_pulse` out 1: one-cycle strobe when a snapshot is taken.

## Operation
- **Synchroniser:** two flops per input (`SW_W`+1 bits total). Reset value is 0.
- **Tick generator:** counter runs 0..`TICK_DIV`-1 and wraps. `tick` is high for the one cycle when the count equals `TICK_DIV`-1. Reset value is 0.
- **Debounce, per bit:**
  - On each tick, shift the synchronised value into a `DB_DEPTH`-bit history.
  - If the history is all ones, the debounced bit becomes 1.
  - If the history is all zeros, the debounced bit becomes 0.
  - Otherwise the debounced bit holds.
  - History and debounced bit reset to 0.
- **Edge detect:** `btn_db_d` is `btn_db` delayed by one cycle. `edge = btn_db & ~btn_db_d`.
- **On `edge`:**
  - `io_rdata_switch` takes `sw_live` as sampled in that same cycle.
  - `confirm_pulse` is 1 for that cycle.
  - `sw_valid` is set to 1.
- **Clearing:** `rd_ack` clears `sw_valid`. If `edge` and `rd_ack` occur in the same cycle, set wins and `sw_valid` stays 1.
- **Holding:** `io_rdata_switch` changes only on `edge`. It is not cleared by `rd_ack`.
- **Repeated presses:** a press while `sw_valid`=1 overwrites the snapshot; no overflow flag.
- **Reset mid-operation:** every register returns to 0 immediately and asynchronously. The tick phase restarts from 0.

## Timing
- **Synchronisation latency:** 2 cycles from a raw change to the synchronised value.
- **Debounce latency:** a clean raw transition appears on `sw_live` after `DB_DEPTH` ticks plus 2–3 cycles. The worst case is `DB_DEPTH`·`TICK_DIV` + `TICK_DIV` + 3 cycles.
- **Bounce rejection:** a glitch shorter than one tick period may be sampled once, but cannot change the output unless it persists for `DB_DEPTH` consecutive ticks.
- **Button to snapshot:**
  - `confirm_pulse` asserts 1 cycle after `btn_db` rises.
  - `io_rdata_switch` and `sw_valid` update on that same edge, visible in the pulse cycle + 0.
- **Reset values:** all outputs are 0.

## Configuration
- **`SWITCH_DEBOUNCE_EN` defined:** tick generator and history debounce are built as described above.
- **`SWITCH_DEBOUNCE_EN` undefined:**
  - Tick counter and histories are not instantiated.
  - The debounced value equals the synchroniser output, so latency is 2 cycles.
  - Edge detect and snapshot logic are unchanged.
  - The undefined build is intended for simulation and fast benches.

## Structure
- **Package `io_pkg`:**
  - `SW_W` default.
  - `DB_DEPTH` default.
  - `TICK_DIV` default.
  - MMIO address constant of the switch register.
- **Sub-module `debounce_bit`:**
  - Ports: `clk`, `rst`, `tick`, `din_sync`, `dout`.
  - Contains the history and the debounced flop.
  - Instantiated `SW_W`+1 times with a shared `tick`.
  - Compiled to a wire when `SWITCH_DEBOUNCE_EN` is undefined.

## Test plan
Benches run with `SWITCH_DEBOUNCE_EN` defined, `TICK_DIV`=4 and `DB_DEPTH`=4 unless stated otherwise.
- **Reset:** assert `rst` mid-count with `sw_raw`=16'hFFFF → all outputs 0. After release, `sw_live`=16'hFFFF within 4·4+4+3 = 23 cycles.
- **Clean capture:** `sw_raw`=16'hA5C3, wait 30 cycles, press `btn_raw` for 30 cycles → `confirm_pulse` is high for exactly 1 cycle. `io_rdata_switch`=16'hA5C3 and `sw_valid`=1.
- **Bounce rejection:** with `sw_live`=0, toggle bit 0 high for 5 cycles then low, repeated 3 times → `sw_live`[0] stays 0. No `confirm_pulse` when the same pattern is applied to `btn_raw`.
- **Ack/edge collision:** drive `rd_ack` in the exact cycle `confirm_pulse`=1 → `sw_valid` remains 1. A later lone `rd_ack` → `sw_valid`=0, `io_rdata_switch` unchanged.
- **Overwrite:** snapshot 16'h1234, change `sw_raw` to 16'h00FF, press again without `rd_ack` → `io_rdata_switch`=16'h00FF and `sw_valid` stays 1.
- **Macro off:** with `SWITCH_DEBOUNCE_EN` undefined, change `sw_raw` to 16'h8001 → `sw_live`=16'h8001 exactly 2 cycles later.
